// File: rtl/mcs4_pkg.sv
// rtl/mcs4_pkg.sv - shared constants and types for the MCS4 ROM loader
package mcs4_pkg;

    localparam int ROM_AW = 12;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_RDBK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM,
        ST_VERIFY,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mcs4_rom_rdchk.sv
// rtl/mcs4_rom_rdchk.sv - readback pipeline tracker and 8-bit readback sum
module mcs4_rom_rdchk #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       clr,
    input  logic       re,
    input  logic [7:0] rdata,
    output logic [7:0] sum,
    output logic       idle
);

    // vld[i] set means a read issued i+1 cycles ago is in flight
    logic [RD_LAT-1:0] vld;

    always_ff @(posedge clk) begin
        if (res || clr) begin
            vld <= '0;
            sum <= '0;
        end else begin
            vld <= RD_LAT'({vld, re});
            if (vld[RD_LAT-1]) begin
                sum <= sum + rdata;
            end
        end
    end

    assign idle = !re && (vld == '0);

endmodule

// File: rtl/mcs4_rom_loader.sv
// rtl/mcs4_rom_loader.sv - framed byte stream to MCS4 ROM loader with readback verify
module mcs4_rom_loader
    import mcs4_pkg::*;
#(
    parameter int                RD_LAT    = 1,
    parameter logic [ROM_AW-1:0] BASE_ADDR = 12'h000,
    parameter logic              BOOT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              res,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              rom_init_enb,
    output logic [ROM_AW-1:0] rom_init_addr,
    output logic              rom_init_re,
    output logic              rom_init_we,
    output logic [7:0]        rom_init_wdata,
    input  logic [7:0]        rom_init_rdata,
    output logic              cpu_res,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    state_t            state, state_n;
    logic [3:0]        len_h, len_h_n;
    logic [ROM_AW-1:0] len, len_n;
    logic [ROM_AW-1:0] idx, idx_n;
    logic [7:0]        sum, sum_n;
    logic              pass, pass_n;
    logic              s_ready_n, enb_n, re_n, we_n, cpu_res_n, busy_n, done_n;
    logic [ROM_AW-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic [1:0]        err_n;
    logic              accept, chk_clr, chk_idle;
    logic [7:0]        rd_sum;

    assign accept = s_valid && s_ready;

    mcs4_rom_rdchk #(.RD_LAT(RD_LAT)) u_rdchk (
        .clk   (clk),
        .res   (res),
        .clr   (chk_clr),
        .re    (rom_init_re),
        .rdata (rom_init_rdata),
        .sum   (rd_sum),
        .idle  (chk_idle)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state          <= ST_IDLE;
            len_h          <= '0;
            len            <= '0;
            idx            <= '0;
            sum            <= '0;
            pass           <= 1'b0;
            s_ready        <= 1'b1;
            rom_init_enb   <= 1'b0;
            rom_init_addr  <= BASE_ADDR;
            rom_init_re    <= 1'b0;
            rom_init_we    <= 1'b0;
            rom_init_wdata <= '0;
            cpu_res        <= BOOT_HOLD;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= ERR_OK;
        end else begin
            state          <= state_n;
            len_h          <= len_h_n;
            len            <= len_n;
            idx            <= idx_n;
            sum            <= sum_n;
            pass           <= pass_n;
            s_ready        <= s_ready_n;
            rom_init_enb   <= enb_n;
            rom_init_addr  <= addr_n;
            rom_init_re    <= re_n;
            rom_init_we    <= we_n;
            rom_init_wdata <= wdata_n;
            cpu_res        <= cpu_res_n;
            busy           <= busy_n;
            done           <= done_n;
            err            <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        len_h_n   = len_h;
        len_n     = len;
        idx_n     = idx;
        sum_n     = sum;
        pass_n    = pass;
        enb_n     = rom_init_enb;
        addr_n    = rom_init_addr;
        re_n      = 1'b0;
        we_n      = 1'b0;
        wdata_n   = rom_init_wdata;
        cpu_res_n = cpu_res;
        done_n    = 1'b0;
        err_n     = err;
        chk_clr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && s_data == SYNC_BYTE) begin
                    state_n   = ST_LEN_H;
                    err_n     = ERR_OK;
                    cpu_res_n = 1'b1;
                    enb_n     = 1'b1;
                end
            end
            ST_LEN_H: begin
                if (accept) begin
                    len_h_n = s_data[3:0];
                    state_n = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (accept) begin
                    len_n   = {len_h, s_data};
                    idx_n   = '0;
                    sum_n   = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_n    = 1'b1;
                    addr_n  = BASE_ADDR + idx;
                    wdata_n = s_data;
                    sum_n   = sum + s_data;
                    idx_n   = idx + 12'd1;
                    if (idx == len) begin
                        state_n = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (s_data != sum) begin
                        err_n   = ERR_CSUM;
                        pass_n  = 1'b0;
                        state_n = ST_FIN;
                    end else begin
                        idx_n   = '0;
                        chk_clr = 1'b1;
                        state_n = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                // reads are issued back-to-back; the checker absorbs the latency
                re_n   = 1'b1;
                addr_n = BASE_ADDR + idx;
                idx_n  = idx + 12'd1;
                if (idx == len) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (chk_idle) begin
                    pass_n = (rd_sum == sum);
                    if (rd_sum != sum) begin
                        err_n = ERR_RDBK;
                    end
                    state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                enb_n = 1'b0;
                if (pass) begin
                    cpu_res_n = 1'b0;
                    done_n    = 1'b1;
                end
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        s_ready_n = state_n inside {ST_IDLE, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM};
        busy_n    = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_mcs4_rom_loader.sv
// tb/tb_mcs4_rom_loader.sv - directed bench for mcs4_rom_loader at two latency/base settings
module tb_mcs4_rom_loader;

    logic        clk = 1'b0;
    logic        res;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        corr;
    logic        mon_clr;

    logic        rdy[2], enb[2], re[2], we[2], cpu[2], busy[2], done[2];
    logic [11:0] addr[2];
    logic [7:0]  wdata[2], rdata[2];
    logic [1:0]  err[2];

    logic [7:0]  mem[2][4096];
    logic [7:0]  pipe[2][4];

    int          wcnt[2], rcnt[2], dcnt[2], ovl[2];
    logic [11:0] wa[2][16], ra[2][16];
    logic [7:0]  wd[2][16];

    int          total = 0;
    int          bad = 0;
    logic [7:0]  fq[$];

    localparam logic [11:0] BASE0 = 12'h000;
    localparam logic [11:0] BASE1 = 12'hFFE;

    always #5 clk = ~clk;

    mcs4_rom_loader #(.RD_LAT(1), .BASE_ADDR(BASE0), .BOOT_HOLD(1'b1)) u0 (
        .clk(clk), .res(res), .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data),
        .rom_init_enb(enb[0]), .rom_init_addr(addr[0]), .rom_init_re(re[0]),
        .rom_init_we(we[0]), .rom_init_wdata(wdata[0]), .rom_init_rdata(rdata[0]),
        .cpu_res(cpu[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    mcs4_rom_loader #(.RD_LAT(3), .BASE_ADDR(BASE1), .BOOT_HOLD(1'b1)) u1 (
        .clk(clk), .res(res), .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data),
        .rom_init_enb(enb[1]), .rom_init_addr(addr[1]), .rom_init_re(re[1]),
        .rom_init_we(we[1]), .rom_init_wdata(wdata[1]), .rom_init_rdata(rdata[1]),
        .cpu_res(cpu[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // ROM models: u0 returns data one cycle after RE, u1 three cycles after
    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][2];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4096; a++) mem[k][a] = 8'h00;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we[k]) mem[k][addr[k]] <= wdata[k];
            pipe[k][0] <= (corr && addr[k] == (k == 0 ? 12'h002 : 12'h000))
                          ? mem[k][addr[k]] + 8'd1 : mem[k][addr[k]];
            for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                wcnt[k] = 0; rcnt[k] = 0; dcnt[k] = 0; ovl[k] = 0;
            end else begin
                if (we[k]) begin
                    if (wcnt[k] < 16) begin wa[k][wcnt[k]] = addr[k]; wd[k][wcnt[k]] = wdata[k]; end
                    wcnt[k]++;
                end
                if (re[k]) begin
                    if (rcnt[k] < 16) ra[k][rcnt[k]] = addr[k];
                    rcnt[k]++;
                end
                if (done[k]) dcnt[k]++;
                if (re[k] && we[k]) ovl[k]++;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!(rdy[0] && rdy[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 16'(t), 16'd0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_q(input bit gaps);
        foreach (fq[i]) send(fq[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic wait_idle(input string p);
        int t = 0;
        while ((busy[0] || busy[1]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({p, "_idle_timeout"}, 16'(t >= 300), 16'd0);
        @(negedge clk);
    endtask

    task automatic chk_result(input string p, input int exp_r, input logic [1:0] exp_err,
                              input logic exp_cpu, input int exp_done);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_u%0d_rcnt", p, k), 16'(rcnt[k]), 16'(exp_r));
            chk($sformatf("%s_u%0d_err", p, k), 16'(err[k]), 16'(exp_err));
            chk($sformatf("%s_u%0d_cpu_res", p, k), 16'(cpu[k]), 16'(exp_cpu));
            chk($sformatf("%s_u%0d_done", p, k), 16'(dcnt[k]), 16'(exp_done));
            chk($sformatf("%s_u%0d_re_we_ovl", p, k), 16'(ovl[k]), 16'd0);
            chk($sformatf("%s_u%0d_enb", p, k), 16'(enb[k]), 16'd0);
        end
    endtask

    // writes of 11,22,33,44 at base..base+3 (mod 4096), reads in the same order
    task automatic chk_frame_a(input string p, input bit reads);
        logic [11:0] ea;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_u%0d_wcnt", p, k), 16'(wcnt[k]), 16'd4);
            for (int i = 0; i < 4; i++) begin
                ea = (k == 0 ? BASE0 : BASE1) + 12'(i);
                chk($sformatf("%s_u%0d_waddr%0d", p, k, i), 16'(wa[k][i]), 16'(ea));
                chk($sformatf("%s_u%0d_wdata%0d", p, k, i), 16'(wd[k][i]), 16'(8'h11 * (i + 1)));
                if (reads) chk($sformatf("%s_u%0d_raddr%0d", p, k, i), 16'(ra[k][i]), 16'(ea));
            end
        end
    endtask

    task automatic load_frame_a(input logic [7:0] cs);
        fq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        fq.push_back(cs);
    endtask

    initial begin
        res = 1'b1; s_valid = 1'b0; s_data = 8'h00; corr = 1'b0; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        res = 1'b0;

        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_u%0d_s_ready", k), 16'(rdy[k]), 16'd1);
            chk($sformatf("rst_u%0d_enb", k), 16'(enb[k]), 16'd0);
            chk($sformatf("rst_u%0d_re_we", k), 16'({re[k], we[k]}), 16'd0);
            chk($sformatf("rst_u%0d_done_busy", k), 16'({done[k], busy[k]}), 16'd0);
            chk($sformatf("rst_u%0d_addr", k), 16'(addr[k]), 16'(k == 0 ? BASE0 : BASE1));
            chk($sformatf("rst_u%0d_wdata", k), 16'(wdata[k]), 16'd0);
            chk($sformatf("rst_u%0d_err", k), 16'(err[k]), 16'd0);
            chk($sformatf("rst_u%0d_cpu_res", k), 16'(cpu[k]), 16'd1);
        end

        // good frame
        clr_mon();
        send(8'hA5, 0);
        chk("hdr_enb", 16'(enb[0] && enb[1]), 16'd1);
        chk("hdr_busy", 16'(busy[0] && busy[1]), 16'd1);
        fq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        send_q(1'b0);
        wait_idle("good");
        chk_result("good", 4, 2'b00, 1'b0, 1);
        chk_frame_a("good", 1'b1);

        // bad stream checksum
        clr_mon();
        load_frame_a(8'hAB);
        send_q(1'b0);
        wait_idle("csum");
        chk_result("csum", 0, 2'b01, 1'b1, 0);
        chk_frame_a("csum", 1'b0);

        // readback corruption at the third byte
        clr_mon();
        corr = 1'b1;
        load_frame_a(8'hAA);
        send_q(1'b0);
        wait_idle("rdbk");
        chk_result("rdbk", 4, 2'b10, 1'b1, 0);
        corr = 1'b0;

        // clean frame clears the error
        clr_mon();
        load_frame_a(8'hAA);
        send_q(1'b0);
        wait_idle("recov");
        chk_result("recov", 4, 2'b00, 1'b0, 1);
        chk_frame_a("recov", 1'b1);

        // leading junk, in-payload sync byte, random gaps
        clr_mon();
        fq = '{8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h00, 8'h04, 8'h01, 8'hA5, 8'h7E, 8'h80, 8'h02, 8'hA6};
        send_q(1'b1);
        wait_idle("gap");
        chk_result("gap", 5, 2'b00, 1'b0, 1);
        chk("gap_u0_wcnt", 16'(wcnt[0]), 16'd5);
        chk("gap_u0_mem0", 16'(mem[0][12'h000]), 16'h01);
        chk("gap_u0_mem1", 16'(mem[0][12'h001]), 16'hA5);
        chk("gap_u0_mem2", 16'(mem[0][12'h002]), 16'h7E);
        chk("gap_u0_mem3", 16'(mem[0][12'h003]), 16'h80);
        chk("gap_u0_mem4", 16'(mem[0][12'h004]), 16'h02);
        chk("gap_u1_memFFE", 16'(mem[1][12'hFFE]), 16'h01);
        chk("gap_u1_memFFF", 16'(mem[1][12'hFFF]), 16'hA5);
        chk("gap_u1_mem000", 16'(mem[1][12'h000]), 16'h7E);
        chk("gap_u1_mem002", 16'(mem[1][12'h002]), 16'h02);

        // reset in the middle of the payload
        clr_mon();
        fq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
        send_q(1'b0);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mid_u%0d_enb", k), 16'(enb[k]), 16'd0);
            chk($sformatf("mid_u%0d_busy", k), 16'(busy[k]), 16'd0);
            chk($sformatf("mid_u%0d_s_ready", k), 16'(rdy[k]), 16'd1);
            chk($sformatf("mid_u%0d_we", k), 16'(we[k]), 16'd0);
            chk($sformatf("mid_u%0d_addr", k), 16'(addr[k]), 16'(k == 0 ? BASE0 : BASE1));
            chk($sformatf("mid_u%0d_cpu_res", k), 16'(cpu[k]), 16'd1);
        end
        clr_mon();
        load_frame_a(8'hAA);
        send_q(1'b0);
        wait_idle("after_rst");
        chk_result("after_rst", 4, 2'b00, 1'b0, 1);
        chk_frame_a("after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
